mem_port_scheduler: RTL and testbench
=====================================

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 Parameter ROB_W, default 5, ROB index width.
REQ-002 Parameter AW, default 16, memory address width.
REQ-003 Parameter DW, default 16, memory data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 ld_valid / ld_rob / ld_addr  input  1 / ROB_W / AW  load-buffer head entry present, ROB tag, address.
REQ-007 ld_ready  output  1  one-cycle pop strobe to load buffer.
REQ-008 st_valid / st_rob / st_addr / st_data  input  1 / ROB_W / AW / DW  store-buffer head entry present, ROB tag, address, data.
REQ-009 st_ready  output  1  one-cycle pop strobe to store buffer.
REQ-010 rob_head  input  ROB_W  ROB index of oldest in-flight instruction.
REQ-011 flush  input  1  pipeline squash; kills speculative loads.
REQ-012 mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / AW / DW  data-memory request, write enable, address, write data.
REQ-013 mem_gnt  input  1  memory accepts request this cycle.
REQ-014 mem_rvalid / mem_rdata  input  1 / DW  load response valid, data.
REQ-015 wb_valid / wb_rob / wb_data  output  1 / ROB_W / DW  load writeback pulse, tag, data.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 Age: x older than y iff (x - rob_head) mod 2^ROB_W < (y - rob_head) mod 2^ROB_W; subtraction ROB_W bits wide, wrap discarded.
REQ-018 Store eligible only when st_valid and st_rob == rob_head.
REQ-019 Load eligible when ld_valid, flush low, and not (st_valid and store older than load).
REQ-020 Both eligible: older one selected; exactly one of ld_ready/st_ready pulses per selection, never both.
REQ-021 States: IDLE, REQ, WAIT, DRAIN.
REQ-022 IDLE: on selection, pulse pop strobe, latch type/tag/addr/data, next state REQ; else stay IDLE.
REQ-023 REQ: mem_req=1 with latched fields stable until mem_gnt; mem_we=1 for store only.
REQ-024 REQ + mem_gnt: store -> IDLE; load -> WAIT (or DRAIN if flush same cycle).
REQ-025 WAIT: on mem_rvalid, wb_valid=1 for one cycle with latched tag and mem_rdata (registered), -> IDLE.
REQ-026 Flush in REQ with latched load and mem_gnt low: drop request, mem_req low next cycle, -> IDLE, no writeback.
REQ-027 Flush in WAIT (without mem_rvalid same cycle) -> DRAIN; DRAIN discards next mem_rvalid, no wb_valid, -> IDLE.
REQ-028 Flush never aborts a latched store; store completes normally.
REQ-029 Flush and mem_rvalid same cycle in WAIT: response discarded, -> IDLE.
REQ-030 Latency: selection cycle N -> mem_req high cycle N+1; load rvalid cycle M -> wb_valid cycle M+1.
REQ-031 mem_rvalid outside WAIT/DRAIN ignored.
REQ-032 No new selection while busy; single outstanding access.

Reset
REQ-033 n_rst low: state IDLE; mem_req, mem_we, ld_ready, st_ready, wb_valid, busy = 0; latched fields, mem_addr, mem_wdata, wb_rob, wb_data = 0.
REQ-034 Reset mid-transaction abandons the access; no writeback after release.

Verification
REQ-035 rob_head=3, ld_rob=5 addr 0x10, no store, mem_gnt=1 next cycle, rvalid 2 cycles later data 0xBEEF -> ld_ready pulse, mem_req 1 cycle we=0, wb_valid tag 5 data 0xBEEF.
REQ-036 rob_head=30, st_rob=30, ld_rob=1 (wrapped, younger) -> store issued first (mem_we=1), load next after IDLE.
REQ-037 rob_head=4, st_rob=6, ld_rob=5 -> load issued; st_ready held low until rob_head=6.
REQ-038 rob_head=4, st_rob=5, ld_rob=7 -> load blocked, nothing issues until rob_head=5, then store, then load.
REQ-039 Load in WAIT, flush pulse, rvalid next cycle -> no wb_valid, busy drops after rvalid; store in REQ with flush -> still completes on mem_gnt.
REQ-040 mem_gnt held low 4 cycles -> mem_req and fields stable 4 cycles; n_rst asserted in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Memory port scheduler: picks the older of the load-buffer head and the
// store-buffer head, drives a single outstanding data-memory access and
// returns load data as a one-cycle writeback pulse. Stores only issue once
// they reach the ROB head. Loads are speculative, so a flush can kill them.
module mem_port_scheduler #(
    parameter int ROB_W = 5,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             ld_valid,
    input  logic [ROB_W-1:0] ld_rob,
    input  logic [AW-1:0]    ld_addr,
    output logic             ld_ready,
    input  logic             st_valid,
    input  logic [ROB_W-1:0] st_rob,
    input  logic [AW-1:0]    st_addr,
    input  logic [DW-1:0]    st_data,
    output logic             st_ready,
    input  logic [ROB_W-1:0] rob_head,
    input  logic             flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [DW-1:0]    mem_rdata,
    output logic             wb_valid,
    output logic [ROB_W-1:0] wb_rob,
    output logic [DW-1:0]    wb_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic             isStore_q, isStore_d;
    logic [ROB_W-1:0] tag_q, tag_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             wbValid_q, wbValid_d;
    logic [ROB_W-1:0] wbRob_q, wbRob_d;
    logic [DW-1:0]    wbData_q, wbData_d;

    logic [ROB_W-1:0] ldAge, stAge;
    logic             stElig, ldElig, pickStore, pickLoad;

    // Age arbitration: distance from rob_head (mod 2^ROB_W) orders the two heads.
    always_comb begin
        ldAge     = ld_rob - rob_head;
        stAge     = st_rob - rob_head;
        stElig    = st_valid && (st_rob == rob_head);
        ldElig    = ld_valid && !flush && !(st_valid && (stAge < ldAge));
        pickStore = stElig && (!ldElig || (stAge <= ldAge));
        pickLoad  = ldElig && !pickStore;
    end

    // Next-state, latched access fields, pop strobes and writeback capture.
    always_comb begin
        state_d   = state_q;
        isStore_d = isStore_q;
        tag_d     = tag_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wbValid_d = 1'b0;
        wbRob_d   = wbRob_q;
        wbData_d  = wbData_q;
        ld_ready  = 1'b0;
        st_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (n_rst && (pickStore || pickLoad)) begin
                    st_ready  = pickStore;
                    ld_ready  = pickLoad;
                    isStore_d = pickStore;
                    tag_d     = pickStore ? st_rob : ld_rob;
                    addr_d    = pickStore ? st_addr : ld_addr;
                    data_d    = pickStore ? st_data : '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (isStore_q)  state_d = IDLE;
                    else if (flush) state_d = DRAIN;
                    else            state_d = WAIT;
                end else if (flush && !isStore_q) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (!flush) begin
                        wbValid_d = 1'b1;
                        wbRob_d   = tag_q;
                        wbData_d  = mem_rdata;
                    end
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            isStore_q <= 1'b0;
            tag_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wbValid_q <= 1'b0;
            wbRob_q   <= '0;
            wbData_q  <= '0;
        end else begin
            state_q   <= state_d;
            isStore_q <= isStore_d;
            tag_q     <= tag_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wbValid_q <= wbValid_d;
            wbRob_q   <= wbRob_d;
            wbData_q  <= wbData_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && isStore_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign wb_valid  = wbValid_q;
    assign wb_rob    = wbRob_q;
    assign wb_data   = wbData_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench for mem_port_scheduler: expected memory accesses and
// writebacks are queued when stimulus is applied and popped when the DUT
// handshakes with memory or pulses wb_valid.
module tb_mem_port_scheduler;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        ld_valid, st_valid, flush, mem_gnt, mem_rvalid;
    logic [4:0]  ld_rob, st_rob, rob_head;
    logic [15:0] ld_addr, st_addr, st_data, mem_rdata;
    logic        ld_ready, st_ready, mem_req, mem_we, wb_valid, busy;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [4:0]  wb_rob;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } memExp_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [15:0] data;
    } wbExp_t;

    memExp_t memQ[$];
    wbExp_t  wbQ[$];
    int      checks = 0;
    int      errors = 0;

    mem_port_scheduler #(.ROB_W(5), .AW(16), .DW(16)) dut (
        .clk(clk), .n_rst(n_rst),
        .ld_valid(ld_valid), .ld_rob(ld_rob), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_rob(st_rob), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .rob_head(rob_head), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_data(wb_data), .busy(busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: act=0x%0h req=0x%0h", tag, act, exp);
        end
    endtask

    // One cycle: scoreboard monitor at negedge, then emulate buffer pops after posedge.
    task automatic tick();
        logic    ldPop, stPop;
        memExp_t me;
        wbExp_t  we;
        @(negedge clk);
        ldPop = ld_ready;
        stPop = st_ready;
        if (ldPop || stPop) checkOutput("onePop", {31'b0, ldPop & stPop}, 32'd0);
        if (mem_req && mem_gnt) begin
            if (memQ.size() == 0) checkOutput("memUnexpected", 32'd1, 32'd0);
            else begin
                me = memQ.pop_front();
                checkOutput("memWe", {31'b0, mem_we}, {31'b0, me.we});
                checkOutput("memAddr", {16'b0, mem_addr}, {16'b0, me.addr});
                if (me.we) checkOutput("memWdata", {16'b0, mem_wdata}, {16'b0, me.data});
            end
        end
        if (wb_valid) begin
            if (wbQ.size() == 0) checkOutput("wbUnexpected", 32'd1, 32'd0);
            else begin
                we = wbQ.pop_front();
                checkOutput("wbRob", {27'b0, wb_rob}, {27'b0, we.tag});
                checkOutput("wbData", {16'b0, wb_data}, {16'b0, we.data});
            end
        end
        @(posedge clk);
        #2;
        if (ldPop) ld_valid = 1'b0;
        if (stPop) st_valid = 1'b0;
    endtask

    task automatic waitReq();
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        checkOutput("reqSeen", {31'b0, mem_req}, 32'd1);
    endtask

    // Wait for a request, hold grant low for a while checking stability, then grant.
    task automatic grant(input int gntDelay, input logic [15:0] expAddr, input logic expWe);
        waitReq();
        for (int i = 0; i < gntDelay; i++) begin
            checkOutput("reqHold", {31'b0, mem_req}, 32'd1);
            checkOutput("addrHold", {16'b0, mem_addr}, {16'b0, expAddr});
            checkOutput("weHold", {31'b0, mem_we}, {31'b0, expWe});
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [15:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input logic lv, input logic [4:0] lr, input logic [15:0] la,
                                 input logic sv, input logic [4:0] sr, input logic [15:0] sa,
                                 input logic [15:0] sd, input logic [4:0] head);
        ld_valid = lv; ld_rob = lr; ld_addr = la;
        st_valid = sv; st_rob = sr; st_addr = sa; st_data = sd;
        rob_head = head;
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        ld_valid = 0; st_valid = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0;
        ld_rob = 0; st_rob = 0; rob_head = 0;
        ld_addr = 0; st_addr = 0; st_data = 0; mem_rdata = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstReq", {31'b0, mem_req}, 32'd0);
        checkOutput("rstWb", {31'b0, wb_valid}, 32'd0);
        checkOutput("rstAddr", {16'b0, mem_addr}, 32'd0);
        checkOutput("rstWbData", {16'b0, wb_data}, 32'd0);
        n_rst = 1'b1;
        tick();

        // Simple load, head 3, tag 5
        applyStimulus(1, 5'd5, 16'h0010, 0, 5'd0, 16'h0, 16'h0, 5'd3);
        checkOutput("s1LdReady", {31'b0, ld_ready}, 32'd1);
        checkOutput("s1StReady", {31'b0, st_ready}, 32'd0);
        memQ.push_back('{we: 1'b0, addr: 16'h0010, data: 16'h0});
        wbQ.push_back('{tag: 5'd5, data: 16'hBEEF});
        grant(0, 16'h0010, 1'b0);
        checkOutput("s1ReqDrop", {31'b0, mem_req}, 32'd0);
        checkOutput("s1BusyWait", {31'b0, busy}, 32'd1);
        tick();
        respond(16'hBEEF);
        checkOutput("s1Idle", {31'b0, busy}, 32'd0);

        // Wrapped ages: head 30, store 30 older than load 1
        applyStimulus(1, 5'd1, 16'h0030, 1, 5'd30, 16'h0020, 16'h1234, 5'd30);
        checkOutput("s2StReady", {31'b0, st_ready}, 32'd1);
        checkOutput("s2LdReady", {31'b0, ld_ready}, 32'd0);
        memQ.push_back('{we: 1'b1, addr: 16'h0020, data: 16'h1234});
        memQ.push_back('{we: 1'b0, addr: 16'h0030, data: 16'h0});
        wbQ.push_back('{tag: 5'd1, data: 16'hA5A5});
        tick();
        checkOutput("s2LdHeldBusy", {31'b0, ld_ready}, 32'd0);
        checkOutput("s2StoreWe", {31'b0, mem_we}, 32'd1);
        grant(0, 16'h0020, 1'b1);
        grant(0, 16'h0030, 1'b0);
        tick();
        respond(16'hA5A5);

        // Load older than store; store waits for head
        applyStimulus(1, 5'd5, 16'h0050, 1, 5'd6, 16'h0040, 16'h6666, 5'd4);
        checkOutput("s3LdReady", {31'b0, ld_ready}, 32'd1);
        checkOutput("s3StReady", {31'b0, st_ready}, 32'd0);
        memQ.push_back('{we: 1'b0, addr: 16'h0050, data: 16'h0});
        wbQ.push_back('{tag: 5'd5, data: 16'h5555});
        grant(0, 16'h0050, 1'b0);
        tick();
        respond(16'h5555);
        tick();
        checkOutput("s3StHeld", {31'b0, st_ready}, 32'd0);
        checkOutput("s3NotBusy", {31'b0, busy}, 32'd0);
        rob_head = 5'd6;
        #1;
        checkOutput("s3StAtHead", {31'b0, st_ready}, 32'd1);
        memQ.push_back('{we: 1'b1, addr: 16'h0040, data: 16'h6666});
        grant(0, 16'h0040, 1'b1);

        // Older store not at head blocks younger load
        applyStimulus(1, 5'd7, 16'h0070, 1, 5'd5, 16'h0060, 16'h7777, 5'd4);
        checkOutput("s4LdBlocked", {31'b0, ld_ready}, 32'd0);
        checkOutput("s4StBlocked", {31'b0, st_ready}, 32'd0);
        tick();
        tick();
        checkOutput("s4Idle", {31'b0, busy}, 32'd0);
        rob_head = 5'd5;
        #1;
        checkOutput("s4StReady", {31'b0, st_ready}, 32'd1);
        memQ.push_back('{we: 1'b1, addr: 16'h0060, data: 16'h7777});
        memQ.push_back('{we: 1'b0, addr: 16'h0070, data: 16'h0});
        wbQ.push_back('{tag: 5'd7, data: 16'h7070});
        grant(0, 16'h0060, 1'b1);
        grant(0, 16'h0070, 1'b0);
        tick();
        respond(16'h7070);

        // Flush in WAIT: DRAIN swallows the response
        applyStimulus(1, 5'd2, 16'h0080, 0, 5'd0, 16'h0, 16'h0, 5'd0);
        memQ.push_back('{we: 1'b0, addr: 16'h0080, data: 16'h0});
        grant(0, 16'h0080, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("s5aDrainBusy", {31'b0, busy}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("s5aNoWb", {31'b0, wb_valid}, 32'd0);
        checkOutput("s5aIdle", {31'b0, busy}, 32'd0);
        tick();

        // Flush while a store waits for grant: store still completes
        applyStimulus(0, 5'd0, 16'h0, 1, 5'd0, 16'h0090, 16'h9999, 5'd0);
        memQ.push_back('{we: 1'b1, addr: 16'h0090, data: 16'h9999});
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("s5bStReq", {31'b0, mem_req}, 32'd1);
        checkOutput("s5bStWe", {31'b0, mem_we}, 32'd1);
        grant(0, 16'h0090, 1'b1);
        checkOutput("s5bIdle", {31'b0, busy}, 32'd0);

        // Flush in REQ with a load and no grant: request dropped
        applyStimulus(1, 5'd1, 16'h00B0, 0, 5'd0, 16'h0, 16'h0, 5'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("s5cReqDrop", {31'b0, mem_req}, 32'd0);
        checkOutput("s5cIdle", {31'b0, busy}, 32'd0);

        // Flush and response in the same WAIT cycle
        applyStimulus(1, 5'd2, 16'h00C0, 0, 5'd0, 16'h0, 16'h0, 5'd0);
        memQ.push_back('{we: 1'b0, addr: 16'h00C0, data: 16'h0});
        grant(0, 16'h00C0, 1'b0);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        checkOutput("s5dNoWb", {31'b0, wb_valid}, 32'd0);
        checkOutput("s5dIdle", {31'b0, busy}, 32'd0);
        tick();

        // Stray response while idle is ignored
        mem_rvalid = 1'b1; mem_rdata = 16'h2222;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("s5eNoWb", {31'b0, wb_valid}, 32'd0);

        // Grant held off 4 cycles, then reset in WAIT
        applyStimulus(1, 5'd3, 16'h00A0, 0, 5'd0, 16'h0, 16'h0, 5'd0);
        memQ.push_back('{we: 1'b0, addr: 16'h00A0, data: 16'h0});
        grant(4, 16'h00A0, 1'b0);
        checkOutput("s6Wait", {31'b0, busy}, 32'd1);
        n_rst = 1'b0;
        #1;
        checkOutput("s6RstReq", {31'b0, mem_req}, 32'd0);
        checkOutput("s6RstBusy", {31'b0, busy}, 32'd0);
        checkOutput("s6RstAddr", {16'b0, mem_addr}, 32'd0);
        checkOutput("s6RstWb", {31'b0, wb_valid}, 32'd0);
        tick();
        n_rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 16'h3333;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("s6NoWb", {31'b0, wb_valid}, 32'd0);
        tick();

        checkOutput("memQEmpty", memQ.size(), 32'd0);
        checkOutput("wbQEmpty", wbQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
